alu_operand_stage: RTL

//   Operand/select stage directly upstream of the ALU in the multicycle MIPS datapath.
//   - Takes register-file reads, PC and the instruction immediate.
//   - Applies the ALUSrcA/ALUSrcB muxing and decodes ALUOp/funct into the ALU 4-bit Sel code.
//   - Registers A, B and Sel behind a valid/ready handshake with a one-entry skid buffer, so
//     the ALU sees stable operands for a whole cycle and upstream never sees ready combinationally from downstream.

---
 rtl/alu_operand_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Selects ALU operands and decodes Sel, then registers them
//               behind a valid/ready handshake with a one-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] pc,
    input  logic [WORD_LENGTH-1:0] rd1,
    input  logic [WORD_LENGTH-1:0] rd2,
    input  logic [15:0]            imm16,
    input  logic                   alu_src_a,
    input  logic [1:0]             alu_src_b,
    input  logic [1:0]             alu_op,
    input  logic [5:0]             funct,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] A,
    output logic [WORD_LENGTH-1:0] B,
    output logic [3:0]             Sel,
    output logic                   illegal
);

    localparam logic [3:0] c_sel_add = 4'b0000;
    localparam logic [3:0] c_sel_sub = 4'b0001;
    localparam logic [3:0] c_sel_mul = 4'b0010;
    localparam logic [3:0] c_sel_and = 4'b0101;
    localparam logic [3:0] c_sel_or  = 4'b0110;
    localparam logic [3:0] c_sel_sll = 4'b1000;
    localparam logic [3:0] c_sel_slt = 4'b1001;
    localparam logic [3:0] c_sel_bad = 4'b1111;

    logic [WORD_LENGTH-1:0] w_a;
    logic [WORD_LENGTH-1:0] w_b;
    logic [WORD_LENGTH-1:0] w_sext;
    logic [3:0]             w_sel;
    logic                   w_illegal;
    logic                   w_accept;
    logic                   w_out_free;

    logic                   r_out_valid;
    logic [WORD_LENGTH-1:0] r_a;
    logic [WORD_LENGTH-1:0] r_b;
    logic [3:0]             r_sel;
    logic                   r_illegal;

    logic                   r_skid_full;
    logic [WORD_LENGTH-1:0] r_skid_a;
    logic [WORD_LENGTH-1:0] r_skid_b;
    logic [3:0]             r_skid_sel;
    logic                   r_skid_illegal;

    assign w_sext = {{(WORD_LENGTH-16){imm16[15]}}, imm16};
    assign w_a    = alu_src_a ? rd1 : pc;

    always_comb begin
        w_b = rd2;
        case (alu_src_b)
            2'b00:   w_b = rd2;
            2'b01:   w_b = WORD_LENGTH'(4);
            2'b10:   w_b = w_sext;
            default: w_b = {w_sext[WORD_LENGTH-3:0], 2'b00};
        endcase
    end

    always_comb begin
        w_sel     = c_sel_add;
        w_illegal = 1'b0;
        case (alu_op)
            2'b00: w_sel = c_sel_add;
            2'b01: w_sel = c_sel_sub;
            2'b11: w_sel = c_sel_slt;
            default: begin
                case (funct)
                    6'b100000: w_sel = c_sel_add;
                    6'b100010: w_sel = c_sel_sub;
                    6'b011000: w_sel = c_sel_mul;
                    6'b100100: w_sel = c_sel_and;
                    6'b100101: w_sel = c_sel_or;
                    6'b101010: w_sel = c_sel_slt;
                    6'b000000: w_sel = c_sel_sll;
                    default: begin
                        w_sel     = c_sel_bad;
                        w_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // in_ready depends only on skid state, never on out_ready
    assign in_ready   = ~r_skid_full;
    assign w_accept   = in_valid & ~r_skid_full;
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
            r_sel          <= 4'b0000;
            r_illegal      <= 1'b0;
            r_skid_full    <= 1'b0;
            r_skid_a       <= '0;
            r_skid_b       <= '0;
            r_skid_sel     <= 4'b0000;
            r_skid_illegal <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_full) begin
                r_out_valid <= 1'b1;
                r_a         <= r_skid_a;
                r_b         <= r_skid_b;
                r_sel       <= r_skid_sel;
                r_illegal   <= r_skid_illegal;
                r_skid_full <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_a         <= w_a;
                r_b         <= w_b;
                r_sel       <= w_sel;
                r_illegal   <= w_illegal;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_full    <= 1'b1;
            r_skid_a       <= w_a;
            r_skid_b       <= w_b;
            r_skid_sel     <= w_sel;
            r_skid_illegal <= w_illegal;
        end
    end

    assign out_valid = r_out_valid;
    assign A         = r_a;
    assign B         = r_b;
    assign Sel       = r_sel;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire
